uart_tx_engine: RTL
===================

# uart_tx_engine

Serial UART transmitter that converts a parallel byte into an asynchronous frame on a single output line. The frame is 1 start bit, 8 data bits sent LSB first, 1 even-parity bit and 1 stop bit. The block is the transmit-side counterpart of the team's UART receiver and uses the same baud_select encoding and the same frame format, so the two can be connected back to back. It contains its own bit-period counter, so it needs no external baud tick.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency used to derive bit-period divisors.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- baud_select  input  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- Tx_EN  input  1  transmitter enable; while low, no new frame is accepted and any frame in progress is aborted.
- Tx_WR  input  1  single-cycle write strobe; requests transmission of Tx_DATA.
- Tx_DATA  input  8  byte to send; sampled only in the cycle a write is accepted.
- TxD  output  1  serial line; idle level is 1.
- Tx_BUSY  output  1  high while a frame is being shifted out.
- Tx_DONE  output  1  one-cycle pulse when a frame completes normally.

## Operation
- Bit period D = floor(CLK_FREQ_HZ / baud). At 50 MHz: 166666, 41666, 10416, 5208, 2604, 1302, 868, 434.
- State machine with five states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TxD=1, Tx_BUSY=0.
  - Accept a write when Tx_WR=1 and Tx_EN=1.
  - On accept, latch Tx_DATA into a shift register, latch parity = XOR of Tx_DATA[7:0], latch D from the current baud_select, clear the bit counter, then go to START.
- START: TxD=0 for D cycles, then go to DATA.
- DATA: TxD = shift_reg[0]. Every D cycles, shift right and increment the bit index. After index 7 has been held for D cycles, go to PARITY.
- PARITY: TxD = latched parity bit for D cycles, then go to STOP.
- STOP: TxD=1 for D cycles, then go to IDLE and pulse Tx_DONE for 1 cycle.
- Width rules:
  - The period counter is 18 bits wide and counts 0..D-1.
  - The bit index is 3 bits wide; its wrap from 7 to 0 coincides with the exit from DATA.
- Boundary conditions:
  - Tx_WR while Tx_BUSY=1 is ignored. No queueing; the in-flight frame is unaffected.
  - Tx_WR in the same cycle that STOP ends (Tx_DONE cycle) is not accepted. It is accepted from the next cycle on, once in IDLE.
  - Tx_EN falling mid-frame aborts the frame: next cycle state=IDLE, TxD=1, Tx_BUSY=0, and no Tx_DONE pulse.
  - Tx_WR while Tx_EN=0 is ignored.
  - A baud_select change mid-frame has no effect until the next accept.
  - Reset mid-frame: TxD=1, Tx_BUSY=0, Tx_DONE=0 immediately and asynchronously; state=IDLE; counters cleared.

## Timing
- Reset values: TxD=1, Tx_BUSY=0, Tx_DONE=0, state=IDLE, all counters 0.
- All outputs are registered.
- Accept at rising edge k means Tx_WR=1 was sampled at edge k. Then:
  - TxD=0 and Tx_BUSY=1 from edge k+1.
  - Data bit i is driven from edge k+1+(1+i)·D.
  - Parity is driven from edge k+1+9D.
  - Stop bit is driven from edge k+1+10D.
  - Tx_BUSY falls and Tx_DONE rises at edge k+1+11D; Tx_DONE falls 1 cycle later.
- Total frame length is 11·D cycles. The earliest next accept is at edge k+2+11D.

## Test plan
- Reset: assert reset mid-DATA of a frame -> TxD=1 and Tx_BUSY=0 immediately; after release, the line stays at 1 with no Tx_DONE pulse.
- baud_select=111, D=434, Tx_DATA=0x55 -> TxD sequence 0,1,0,1,0,1,0,1,0,0,1, each bit 434 cycles. Tx_BUSY is high for exactly 4774 cycles, followed by a single Tx_DONE pulse.
- baud_select=111, Tx_DATA=0xA7 -> data bits 1,1,1,0,0,1,0,1, parity=1, stop=1. Tx_WR=1 with Tx_DATA=0x00 pulsed mid-frame -> ignored; the line is unchanged.
- baud_select=011, D=5208, Tx_DATA=0x00 -> start bit low for 5208 cycles, parity=0, frame length 57288 cycles. Change baud_select to 111 mid-frame -> bit width stays 5208.
- Tx_EN dropped during PARITY of a 0xFF frame -> next cycle TxD=1 and Tx_BUSY=0, with no Tx_DONE. With Tx_EN=0, Tx_WR -> no start bit.
- Back to back: send 0x3C, then assert Tx_WR on the cycle after Tx_DONE with 0xC3 -> second start bit begins 1 cycle after the first frame's stop bit ends. The loopback receiver reports 0x3C then 0xC3 with no parity or framing error.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmitter: 1 start, 8 data bits LSB first, even parity, 1 stop; own bit-period counter.
// Latency: TxD leaves idle the cycle after a write is accepted; a frame lasts 11 bit periods.
// Backpressure: writes are accepted only while idle and enabled; others are dropped, never queued.
module uart_tx_engine #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

    // Bit-period divisors, truncated clock/baud ratios
    localparam logic [17:0] DIV_300    = 18'(CLK_FREQ_HZ / 300);
    localparam logic [17:0] DIV_1200   = 18'(CLK_FREQ_HZ / 1200);
    localparam logic [17:0] DIV_4800   = 18'(CLK_FREQ_HZ / 4800);
    localparam logic [17:0] DIV_9600   = 18'(CLK_FREQ_HZ / 9600);
    localparam logic [17:0] DIV_19200  = 18'(CLK_FREQ_HZ / 19200);
    localparam logic [17:0] DIV_38400  = 18'(CLK_FREQ_HZ / 38400);
    localparam logic [17:0] DIV_57600  = 18'(CLK_FREQ_HZ / 57600);
    localparam logic [17:0] DIV_115200 = 18'(CLK_FREQ_HZ / 115200);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic [17:0] r_div;
    logic [17:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_txd;
    logic        r_busy;
    logic        r_done;

    logic [17:0] w_div_sel;
    logic        w_bit_end;
    logic        w_accept;

    // Map the rate code to its bit period; only consulted at accept time
    always_comb begin
        w_div_sel = DIV_115200;
        case (baud_select)
            3'b000:  w_div_sel = DIV_300;
            3'b001:  w_div_sel = DIV_1200;
            3'b010:  w_div_sel = DIV_4800;
            3'b011:  w_div_sel = DIV_9600;
            3'b100:  w_div_sel = DIV_19200;
            3'b101:  w_div_sel = DIV_38400;
            3'b110:  w_div_sel = DIV_57600;
            default: w_div_sel = DIV_115200;
        endcase
    end

    // The latched divisor, not the live rate code, times the frame in flight
    assign w_bit_end = (r_cnt == (r_div - 18'd1));
    assign w_accept  = Tx_WR & Tx_EN;

    // Frame state machine; line, busy and done are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_div     <= 18'd0;
            r_cnt     <= 18'd0;
            r_bit_idx <= 3'd0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != ST_IDLE) && !Tx_EN) begin
                // Enable dropped mid-frame: abandon it silently, no done pulse
                r_state   <= ST_IDLE;
                r_cnt     <= 18'd0;
                r_bit_idx <= 3'd0;
                r_txd     <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_txd  <= 1'b1;
                        r_busy <= 1'b0;
                        if (w_accept) begin
                            r_shift   <= Tx_DATA;
                            r_parity  <= ^Tx_DATA;
                            r_div     <= w_div_sel;
                            r_cnt     <= 18'd0;
                            r_bit_idx <= 3'd0;
                            r_txd     <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (w_bit_end) begin
                            r_cnt   <= 18'd0;
                            r_txd   <= r_shift[0];
                            r_state <= ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                    ST_DATA: begin
                        if (w_bit_end) begin
                            r_cnt     <= 18'd0;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            // Index wraps 7->0 exactly as the last data bit finishes
                            if (r_bit_idx == 3'd7) begin
                                r_txd   <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_txd <= r_shift[1];
                            end
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (w_bit_end) begin
                            r_cnt   <= 18'd0;
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                    ST_STOP: begin
                        if (w_bit_end) begin
                            r_cnt   <= 18'd0;
                            r_txd   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 18'd1;
                        end
                    end
                    default: begin
                        r_cnt     <= 18'd0;
                        r_bit_idx <= 3'd0;
                        r_txd     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign TxD     = r_txd;
    assign Tx_BUSY = r_busy;
    assign Tx_DONE = r_done;

endmodule
